// File: rtl/multicycle_controller.sv
// multicycle_controller
//   Control unit for the shared-memory multicycle ARM-subset datapath. Decodes
//   op/funct/rd/cond from the instruction register, sequences the datapath
//   through a ten-state FSM and holds the architectural NZCV register. Each
//   instruction is checked against its condition code here.
//
// Parameters
//   ALU_CTRL_W : alu_control width. 2 = ADD/SUB/AND/ORR. 3 also allows EOR (100)
//                and MOV (101).
//   FLAG_W     : flag register width, NZCV in bits [3:0].
//
// Ports
//   clk, rst_n        : clock, asynchronous active-low reset
//   cond/op/funct/rd  : instruction fields Instr[31:28], [27:26], [25:20], Rd
//   alu_flags         : NZCV produced by the ALU this cycle
//   mem_ready         : memory access completes this cycle
//   pc_write, mem_write, ir_write, reg_write : write strobes
//   adr_src, alu_src_a, alu_src_b, result_src, imm_src, reg_src : mux selects
//   alu_control       : ALU operation
//   flags             : architectural NZCV register
//   undef             : one-cycle pulse in DECODE for an unsupported command
module multicycle_controller #(
    parameter int ALU_CTRL_W = 2,
    parameter int FLAG_W     = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [3:0]            cond,
    input  logic [1:0]            op,
    input  logic [5:0]            funct,
    input  logic [3:0]            rd,
    input  logic [FLAG_W-1:0]     alu_flags,
    input  logic                  mem_ready,
    output logic                  pc_write,
    output logic                  adr_src,
    output logic                  mem_write,
    output logic                  ir_write,
    output logic                  reg_write,
    output logic                  alu_src_a,
    output logic [1:0]            alu_src_b,
    output logic [1:0]            result_src,
    output logic [1:0]            imm_src,
    output logic [1:0]            reg_src,
    output logic [ALU_CTRL_W-1:0] alu_control,
    output logic [FLAG_W-1:0]     flags,
    output logic                  undef
);

    localparam bit HAS_EXT_OPS = (ALU_CTRL_W >= 3);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB,
        S_MEMWR, S_EXECR, S_EXECI, S_ALUWB, S_BRANCH
    } state_t;

    state_t            state_reg;
    logic [FLAG_W-1:0] flags_reg;
    logic              cond_ex_reg;

    logic [3:0] cmd;
    logic       s_bit;
    logic       cmd_ok;
    logic       cmd_cv;
    logic       cmd_cmp;
    logic [2:0] alu_code;
    logic       cond_ex;

    logic pc_w, mem_w, ir_w, reg_w;

    assign cmd   = funct[4:1];
    assign s_bit = funct[0];
    assign flags = flags_reg;

    // Command decode: support flag, ALU code and whether C/V are produced.
    always_comb begin
        cmd_ok   = 1'b0;
        cmd_cv   = 1'b0;
        cmd_cmp  = 1'b0;
        alu_code = 3'b000;
        case (cmd)
            4'b0100: begin cmd_ok = 1'b1; alu_code = 3'b000; cmd_cv = 1'b1; end
            4'b0010: begin cmd_ok = 1'b1; alu_code = 3'b001; cmd_cv = 1'b1; end
            4'b0000: begin cmd_ok = 1'b1; alu_code = 3'b010; end
            4'b1100: begin cmd_ok = 1'b1; alu_code = 3'b011; end
            4'b1010: begin cmd_ok = 1'b1; alu_code = 3'b001; cmd_cv = 1'b1; cmd_cmp = 1'b1; end
            4'b0001: begin cmd_ok = HAS_EXT_OPS; alu_code = 3'b100; end
            4'b1101: begin cmd_ok = HAS_EXT_OPS; alu_code = 3'b101; end
            default: ;
        endcase
    end

    // Condition evaluation against the registered flags; 1111 never executes.
    always_comb begin
        case (cond)
            4'h0:    cond_ex = flags_reg[2];
            4'h1:    cond_ex = ~flags_reg[2];
            4'h2:    cond_ex = flags_reg[1];
            4'h3:    cond_ex = ~flags_reg[1];
            4'h4:    cond_ex = flags_reg[3];
            4'h5:    cond_ex = ~flags_reg[3];
            4'h6:    cond_ex = flags_reg[0];
            4'h7:    cond_ex = ~flags_reg[0];
            4'h8:    cond_ex = flags_reg[1] & ~flags_reg[2];
            4'h9:    cond_ex = ~flags_reg[1] | flags_reg[2];
            4'ha:    cond_ex = (flags_reg[3] == flags_reg[0]);
            4'hb:    cond_ex = (flags_reg[3] != flags_reg[0]);
            4'hc:    cond_ex = ~flags_reg[2] & (flags_reg[3] == flags_reg[0]);
            4'hd:    cond_ex = flags_reg[2] | (flags_reg[3] != flags_reg[0]);
            4'he:    cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= S_FETCH;
            flags_reg   <= '0;
            cond_ex_reg <= 1'b0;
        end else begin
            case (state_reg)
                S_FETCH:  if (mem_ready) state_reg <= S_DECODE;
                S_DECODE: begin
                    case (op)
                        2'b01:   state_reg <= S_MEMADR;
                        2'b10:   state_reg <= S_BRANCH;
                        2'b00:   state_reg <= !cmd_ok ? S_FETCH :
                                              (funct[5] ? S_EXECI : S_EXECR);
                        default: state_reg <= S_FETCH;
                    endcase
                end
                S_MEMADR: state_reg <= funct[0] ? S_MEMRD : S_MEMWR;
                S_MEMRD:  if (mem_ready) state_reg <= S_MEMWB;
                S_MEMWR:  if (mem_ready) state_reg <= S_FETCH;
                S_EXECR, S_EXECI: begin
                    state_reg <= S_ALUWB;
                    // ALUWB must see the condition as it was before this
                    // instruction touched the flags, so keep the EXEC verdict.
                    cond_ex_reg <= cond_ex;
                    if (cond_ex && s_bit) begin
                        flags_reg[3:2] <= alu_flags[3:2];
                        if (cmd_cv) flags_reg[1:0] <= alu_flags[1:0];
                    end
                end
                default:  state_reg <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        pc_w        = 1'b0;
        mem_w       = 1'b0;
        ir_w        = 1'b0;
        reg_w       = 1'b0;
        adr_src     = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        result_src  = 2'b00;
        imm_src     = 2'b00;
        reg_src     = 2'b00;
        alu_control = '0;
        undef       = 1'b0;
        case (state_reg)
            S_FETCH: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_w       = mem_ready;
                pc_w       = mem_ready;
            end
            S_DECODE: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                imm_src    = (op == 2'b01) ? 2'b01 : (op == 2'b10) ? 2'b10 : 2'b00;
                reg_src    = {op == 2'b01, op == 2'b10};
                undef      = (op == 2'b11) || ((op == 2'b00) && !cmd_ok);
            end
            S_MEMADR: begin
                alu_src_b = 2'b01;
                imm_src   = 2'b01;
            end
            S_MEMRD:  adr_src = 1'b1;
            S_MEMWR: begin
                adr_src = 1'b1;
                mem_w   = cond_ex;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_w      = cond_ex;
                pc_w       = cond_ex && (rd == 4'hf);
            end
            S_EXECR, S_EXECI: begin
                alu_src_b   = (state_reg == S_EXECI) ? 2'b01 : 2'b00;
                alu_control = ALU_CTRL_W'(alu_code);
            end
            S_ALUWB: begin
                reg_w = cond_ex_reg && !cmd_cmp;
                pc_w  = cond_ex_reg && !cmd_cmp && (rd == 4'hf);
            end
            S_BRANCH: begin
                alu_src_b  = 2'b01;
                imm_src    = 2'b10;
                result_src = 2'b10;
                pc_w       = cond_ex;
            end
            default: ;
        endcase
    end

    // Write strobes are forced low for as long as reset is held.
    assign pc_write  = pc_w  & rst_n;
    assign mem_write = mem_w & rst_n;
    assign ir_write  = ir_w  & rst_n;
    assign reg_write = reg_w & rst_n;

endmodule
